// File: rtl/conv1d_mac_ctrl_if.sv
// conv1d_mac_ctrl_if: start/tap-count, buffer read, multiplier and result-handshake bundle for conv1d_mac_ctrl
interface conv1d_mac_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int MAX_TAPS = 16
);
  localparam int CW = $clog2(MAX_TAPS + 1);
  logic                        start_i;
  logic [CW-1:0]               taps_i;
  logic                        busy_o;
  logic                        rd_en_o;
  logic [CW-2:0]               rd_addr_o;
  logic signed [WIDTH-1:0]     sample_i;
  logic signed [WIDTH-1:0]     weight_i;
  logic signed [WIDTH-1:0]     mult_a_o;
  logic signed [WIDTH-1:0]     mult_b_o;
  logic signed [4*WIDTH-1:0]   prod_i;
  logic signed [4*WIDTH-1:0]   result_o;
  logic                        result_valid_o;
  logic                        result_ready_i;
  modport slave (
    input  start_i, taps_i, sample_i, weight_i, prod_i, result_ready_i,
    output busy_o, rd_en_o, rd_addr_o, mult_a_o, mult_b_o, result_o, result_valid_o
  );
  modport master (
    output start_i, taps_i, sample_i, weight_i, prod_i, result_ready_i,
    input  busy_o, rd_en_o, rd_addr_o, mult_a_o, mult_b_o, result_o, result_valid_o
  );
endinterface

// File: rtl/conv1d_mac_ctrl.sv
// conv1d_mac_ctrl: sequences tap reads into an external multiplier and accumulates a signed dot product.
// Define CONV1D_RELU_EN to clamp negative results to zero.
module conv1d_mac_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX_TAPS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  conv1d_mac_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_TAPS + 1);
  localparam int AW = CW - 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             n_q, n_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [4*WIDTH-1:0] acc_q, acc_d;
  logic                      rd_en_q;
  logic [CW-1:0]             taps_clamped;
  assign taps_clamped = (bus.taps_i > CW'(MAX_TAPS)) ? CW'(MAX_TAPS) : bus.taps_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      rd_en_q <= bus.rd_en_o;
    end
  end
  // Buffer data, and hence prod_i, lags each read strobe by one cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = rd_en_q ? acc_q + bus.prod_i : acc_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        n_d     = taps_clamped;
        idx_d   = '0;
        acc_d   = '0;
        state_d = (taps_clamped == '0) ? DONE : FETCH;
      end
      FETCH: begin
        idx_d   = ({1'b0, idx_q} == n_q - 1'b1) ? '0 : idx_q + 1'b1;
        state_d = ({1'b0, idx_q} == n_q - 1'b1) ? DRAIN : FETCH;
      end
      DRAIN:   state_d = DONE;
      default: state_d = bus.result_ready_i ? IDLE : DONE;
    endcase
  end
  assign bus.busy_o         = state_q != IDLE;
  assign bus.rd_en_o        = state_q == FETCH;
  assign bus.rd_addr_o      = (state_q == FETCH) ? idx_q : '0;
  assign bus.mult_a_o       = bus.sample_i;
  assign bus.mult_b_o       = bus.weight_i;
  assign bus.result_valid_o = state_q == DONE;
`ifdef CONV1D_RELU_EN
  assign bus.result_o = acc_q[4*WIDTH-1] ? '0 : acc_q;
`else
  assign bus.result_o = acc_q;
`endif
endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// tb_conv1d_mac_ctrl: directed checks of conv1d_mac_ctrl with a buffer model and an external multiplier model
module tb_conv1d_mac_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int failures = 0;
  int reads = 0;
  int r0;
  logic signed [7:0] smem [16];
  logic signed [7:0] wmem [16];
  logic signed [31:0] pa, pb;
  conv1d_mac_ctrl_if #(.WIDTH(8), .MAX_TAPS(16)) bus ();
  conv1d_mac_ctrl #(.WIDTH(8), .MAX_TAPS(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
  always #5 clk_i = ~clk_i;
  assign pa = bus.mult_a_o;
  assign pb = bus.mult_b_o;
  assign bus.prod_i = pa * pb;
  always @(posedge clk_i) begin
    if (bus.rd_en_o) begin
      bus.sample_i <= smem[bus.rd_addr_o];
      bus.weight_i <= wmem[bus.rd_addr_o];
      reads <= reads + 1;
    end
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_rden"}, 32'(bus.rd_en_o), 0);
    chk({tag, "_addr"}, 32'(bus.rd_addr_o), 0);
    chk({tag, "_valid"}, 32'(bus.result_valid_o), 0);
  endtask
  task automatic go(input int n);
    bus.start_i = 1'b1;
    bus.taps_i  = 5'(n);
    tick();
    bus.start_i = 1'b0;
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.taps_i = '0;
    bus.result_ready_i = 1'b1;
    bus.sample_i = '0;
    bus.weight_i = '0;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; wmem[i] = '0; end
    #1;
    chk_idle("rst");
    chk("rst_result", bus.result_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    smem[0] = 1; smem[1] = 2; smem[2] = 3;
    wmem[0] = 4; wmem[1] = 5; wmem[2] = 6;
    go(3);
    for (int i = 0; i < 3; i++) begin
      chk("n3_busy", 32'(bus.busy_o), 1);
      chk("n3_rden", 32'(bus.rd_en_o), 1);
      chk("n3_addr", 32'(bus.rd_addr_o), i);
      tick();
    end
    chk("n3_drain_rden", 32'(bus.rd_en_o), 0);
    chk("n3_drain_valid", 32'(bus.result_valid_o), 0);
    tick();
    chk("n3_valid", 32'(bus.result_valid_o), 1);
    chk("n3_result", bus.result_o, 32);
    tick();
    chk_idle("n3_after");
    r0 = reads;
    go(0);
    chk("n0_valid", 32'(bus.result_valid_o), 1);
    chk("n0_result", bus.result_o, 0);
    chk("n0_rden", 32'(bus.rd_en_o), 0);
    tick();
    chk("n0_reads", reads - r0, 0);
    chk_idle("n0_after");
    smem[0] = -128; smem[1] = -128;
    wmem[0] = 127;  wmem[1] = 127;
    go(2);
    tick();
    tick();
    chk("neg_pre_valid", 32'(bus.result_valid_o), 0);
    tick();
    chk("neg_valid", 32'(bus.result_valid_o), 1);
`ifdef CONV1D_RELU_EN
    chk("neg_result", bus.result_o, 0);
`else
    chk("neg_result", bus.result_o, 32'hFFFF_8100);
`endif
    tick();
    smem[0] = 1; smem[1] = 2; smem[2] = 3;
    wmem[0] = 4; wmem[1] = 5; wmem[2] = 6;
    bus.result_ready_i = 1'b0;
    r0 = reads;
    go(3);
    bus.start_i = 1'b1;
    bus.taps_i = 5'd5;
    tick();
    chk("hold_fetch_addr", 32'(bus.rd_addr_o), 1);
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(bus.result_valid_o), 1);
      chk("hold_result", bus.result_o, 32);
      tick();
    end
    chk("hold_valid_last", 32'(bus.result_valid_o), 1);
    bus.result_ready_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("hold_reads", reads - r0, 3);
    chk_idle("hold_after");
    tick();
    chk("hold_start_lost", 32'(bus.busy_o), 0);
    go(3);
    tick();
    chk("rst_mid_addr_pre", 32'(bus.rd_addr_o), 1);
    rst_i = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_result", bus.result_o, 0);
    tick();
    rst_i = 1'b0;
    smem[0] = 7; wmem[0] = -3;
    go(1);
    chk("n1_addr", 32'(bus.rd_addr_o), 0);
    tick();
    tick();
    chk("n1_valid", 32'(bus.result_valid_o), 1);
    chk("n1_result", bus.result_o, 32'hFFFF_FFEB);
    tick();
    for (int i = 0; i < 16; i++) begin smem[i] = 8'(i); wmem[i] = 1; end
    r0 = reads;
    go(20);
    for (int i = 0; i < 16; i++) begin
      chk("clamp_rden", 32'(bus.rd_en_o), 1);
      chk("clamp_addr", 32'(bus.rd_addr_o), i);
      tick();
    end
    chk("clamp_drain_rden", 32'(bus.rd_en_o), 0);
    tick();
    chk("clamp_valid", 32'(bus.result_valid_o), 1);
    chk("clamp_result", bus.result_o, 120);
    chk("clamp_reads", reads - r0, 16);
    tick();
    chk_idle("clamp_after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
